// File: rtl/instr_fetch.sv
// Instruction fetch front end.
// Drives the synchronous instruction ROM address, absorbs the ROM's one-cycle
// read latency and buffers {pc, instr} pairs in a small FIFO, so decode can
// stall with valid/ready. A redirect flushes everything and restarts fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

    // Fetch-side state
    logic [31:0] fetch_pc_reg;
    logic        inflight_reg;
    logic [31:0] inflight_pc_reg;

    // FIFO state
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [31:0]   pc_mem_reg    [DEPTH];
    logic [31:0]   instr_mem_reg [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    logic       pop;
    logic       push;
    logic       issue;
    logic [CW:0] occupancy;

    // Wrap-around pointer increment that also works for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A redirect hides the head immediately so decode never takes a stale word.
    assign out_valid = (count_reg != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    // The returning ROM word is dropped when a redirect arrives in the same cycle.
    assign push      = inflight_reg & ~redirect_valid;

    // Slots that will be spoken for after this edge: buffered + returning - leaving.
    // Issuing only while this stays below DEPTH guarantees the FIFO can never overflow.
    assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, pop};
    assign issue     = fetch_en & ~redirect_valid & (occupancy < DEPTH_OCC);

    assign imem_addr = fetch_pc_reg;
    assign out_pc    = pc_mem_reg[rd_ptr_reg];
    assign out_instr = instr_mem_reg[rd_ptr_reg];

    // PC / in-flight tracking: redirect wins, otherwise issue advances the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= 32'h0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc & ~32'h3;
            inflight_reg <= 1'b0;
        end else if (issue) begin
            inflight_reg    <= 1'b1;
            inflight_pc_reg <= fetch_pc_reg;
            fetch_pc_reg    <= fetch_pc_reg + 32'd4;
        end else begin
            inflight_reg <= 1'b0;
        end
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointers and count; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (redirect_valid) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // One write-select line per FIFO slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push & (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Slot storage; cleared on reset so the head fields read zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_reg[i]    <= 32'h0;
                instr_mem_reg[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    pc_mem_reg[i]    <= inflight_pc_reg;
                    instr_mem_reg[i] <= imem_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered ROM model (word[i] = A0000000 + i).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_pc;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the sampled address appears one cycle later.
    always @(posedge clk) imem_data <= 32'hA000_0000 + {24'h0, imem_addr[9:2]};

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA000_0000 + {24'h0, a[9:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Head entry must be valid and carry pc with its ROM word.
    task automatic word(input string tag, input logic [31:0] pc);
        chk_bit({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, rom(pc));
        $display("head %s pc=%h instr=%h ready=%b", tag, out_pc, out_instr, out_ready);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        #1;
        chk_bit("rst_valid", out_valid, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        step();
        step();

        // T1: release reset, first word after two edges, then one per cycle
        rst_n = 1'b1;
        step();
        chk_bit("t1_e1_valid", out_valid, 1'b0);
        chk("t1_e1_addr", imem_addr, 32'h4);
        step();
        for (int i = 0; i < 8; i++) begin
            word("t1", 32'(i * 4));
            step();
        end

        // T2: stall six cycles, FIFO fills, address holds, stream resumes in order
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            word("t2_hold", 32'h20);
        end
        chk("t2_addr_held", imem_addr, 32'h28);
        out_ready = 1'b1;
        exp_pc = 32'h20;
        for (int i = 0; i < 4; i++) begin
            word("t2_resume", exp_pc);
            exp_pc += 32'd4;
            step();
        end

        // T3: redirect to 0x43 with a word buffered and one in flight
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #1;
        chk_bit("t3_valid_during", out_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk_bit("t3_e0_valid", out_valid, 1'b0);
        chk("t3_e0_addr", imem_addr, 32'h40);
        step();
        chk_bit("t3_e1_valid", out_valid, 1'b0);
        step();
        exp_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            word("t3", exp_pc);
            exp_pc += 32'd4;
            step();
        end

        // T4: fetch disabled for four cycles, buffered and in-flight words drain
        fetch_en = 1'b0;
        #1;
        word("t4_drain", 32'h4C);
        step();
        word("t4_drain", 32'h50);
        step();
        chk_bit("t4_empty_a", out_valid, 1'b0);
        step();
        chk_bit("t4_empty_b", out_valid, 1'b0);
        step();
        chk_bit("t4_empty_c", out_valid, 1'b0);
        chk("t4_addr_held", imem_addr, 32'h54);
        fetch_en = 1'b1;
        step();
        chk_bit("t4_restart_valid", out_valid, 1'b0);
        step();
        word("t4_resume", 32'h54);
        step();
        word("t4_resume", 32'h58);
        step();

        // Redirect while fetch is disabled still flushes and loads the PC
        fetch_en       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        chk_bit("rdis_valid_during", out_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rdis_addr", imem_addr, 32'h200);
        chk_bit("rdis_valid_a", out_valid, 1'b0);
        step();
        chk("rdis_addr_held", imem_addr, 32'h200);
        chk_bit("rdis_valid_b", out_valid, 1'b0);
        fetch_en = 1'b1;
        step();
        chk_bit("rdis_valid_c", out_valid, 1'b0);
        step();
        word("rdis", 32'h200);
        step();

        // T5: back-to-back redirects (last wins, low bits masked), PC wraps past 2^32
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk_bit("t5_valid_during", out_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        chk_bit("t5_e0_valid", out_valid, 1'b0);
        step();
        chk("t5_addr_wrap", imem_addr, 32'h0);
        chk_bit("t5_e1_valid", out_valid, 1'b0);
        step();
        word("t5", 32'hFFFF_FFFC);
        step();
        word("t5", 32'h0);
        step();
        word("t5", 32'h4);
        step();
        exp_pc = 32'h8;

        // T6: random back-pressure, then asynchronous reset mid-stream
        for (int i = 0; i < 12; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk_bit("t6_valid", out_valid, 1'b1);
            if (out_valid && out_ready) begin
                word("t6", exp_pc);
                exp_pc += 32'd4;
            end
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_pc", out_pc, 32'h0);
        chk("t6_rst_instr", out_instr, 32'h0);
        step();
        chk("t6_rst_addr_hold", imem_addr, 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk_bit("t6_e1_valid", out_valid, 1'b0);
        chk("t6_e1_addr", imem_addr, 32'h4);
        step();
        for (int i = 0; i < 4; i++) begin
            word("t6_restart", 32'(i * 4));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
